// File: rtl/cla_nibble_seq_ctrl.sv
// WIDTH-bit add/subtract sequencer driving one registered 4-bit CLA adder a nibble at a time.
// Optional perf counters (perf_ops, perf_busy) enabled by defining CLA_SEQ_PERF_EN.
module cla_nibble_seq_ctrl #(
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
`ifdef CLA_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_ops,
  output logic [15:0]      perf_busy
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int LW      = (ADD_LAT > 2) ? $clog2(ADD_LAT - 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [IW-1:0]    r_idx;
  logic [LW-1:0]    r_lat;

  logic [WIDTH-1:0] w_bp;
  logic             w_c0, w_last;
  logic [IW-1:0]    w_idx_nxt;

  // Subtract is A + ~B + 1; req_cin only matters for add.
  assign w_bp      = req_sub ? ~req_b : req_b;
  assign w_c0      = req_sub | req_cin;
  assign w_last    = (r_idx == IW'(NIBBLES - 1));
  assign w_idx_nxt = r_idx + 1'b1;
  assign rsp_sum   = r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_idx     <= '0;
      r_lat     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_a       <= req_a;
          r_b       <= w_bp;
          r_sum     <= '0;
          r_idx     <= '0;
          add_a     <= req_a[3:0];
          add_b     <= w_bp[3:0];
          add_cin   <= w_c0;
          req_ready <= 1'b0;
          r_state   <= S_ISSUE;
        end
        S_ISSUE: begin
          r_lat   <= '0;
          r_state <= (ADD_LAT > 1) ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          if (r_lat == LW'(ADD_LAT - 2)) r_state <= S_CAPTURE;
          else                           r_lat   <= r_lat + 1'b1;
        end
        S_CAPTURE: begin
          r_sum[4*r_idx +: 4] <= add_sum;
          if (!w_last) begin
            // Next nibble is presented on the same edge, so ISSUE sees it immediately.
            r_idx   <= w_idx_nxt;
            add_a   <= r_a[4*w_idx_nxt +: 4];
            add_b   <= r_b[4*w_idx_nxt +: 4];
            add_cin <= add_cout;
            r_state <= S_ISSUE;
          end else begin
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_cout  <= add_cout;
            rsp_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_sum[3] != r_a[WIDTH-1]);
            rsp_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CLA_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (rsp_valid && rsp_ready && perf_ops != 16'hFFFF) perf_ops <= perf_ops + 1'b1;
      if (r_state != S_IDLE && perf_busy != 16'hFFFF)     perf_busy <= perf_busy + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Scoreboard bench for cla_nibble_seq_ctrl with a behavioural registered 4-bit adder.
module tb_cla_nibble_seq_ctrl;
  localparam int W   = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_cin = 1'b0, req_sub = 1'b0;
  logic [W-1:0]  req_a = '0, req_b = '0, rsp_sum;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_cout, rsp_ovf;
  logic [3:0]    add_a, add_b, add_sum;
  logic          add_cin, add_cout;
`ifdef CLA_SEQ_PERF_EN
  logic [15:0]   perf_ops, perf_busy;
`endif

  int checks = 0, errors = 0;

  typedef struct packed { logic [W-1:0] sum; logic cout; logic ovf; } rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  cla_nibble_seq_ctrl #(.WIDTH(W), .ADD_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
`ifdef CLA_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
  );

  // Registered adder: LAT stages, result visible LAT edges after sampling.
  logic [4:0] apipe [LAT];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LAT; k++) apipe[k] <= '0;
    end else begin
      apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
      for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
  end
  assign add_sum  = apipe[LAT-1][3:0];
  assign add_cout = apipe[LAT-1][4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: compare every response handshake against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      rsp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      end
    end
  end

  // Carry into nibble k of A + B' + c.
  function automatic logic carry_in(input logic [W-1:0] a, input logic [W-1:0] bp, input logic c, input int k);
    logic [W:0] s;
    logic [W-1:0] m;
    m = (k == 0) ? '0 : ({W{1'b1}} >> (W - 4*k));
    s = {1'b0, a & m} + {1'b0, bp & m} + {{W{1'b0}}, c};
    return s[4*k];
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin; req_sub = sub;
    @(posedge clk); #1;
    // Scramble the request bus: it must be ignored after acceptance.
    req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom);
    req_cin = 1'($urandom); req_sub = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int stall, input logic [W-1:0] esum,
                       input logic ecout, input logic eovf);
    logic [W-1:0] bp;
    logic c0;
    int n;
    bp = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    exp_q.push_back('{sum: esum, cout: ecout, ovf: eovf});
    accept(a, b, cin, sub);
    n = 0;
    while (!rsp_valid && n < 100) begin
      if (n % (LAT+1) == 0 && n < 4*(LAT+1)) begin
        chk("add_a_nib", 32'(add_a), 32'(a[4*(n/(LAT+1)) +: 4]));
        chk("add_b_nib", 32'(add_b), 32'(bp[4*(n/(LAT+1)) +: 4]));
        chk("add_cin_nib", 32'(add_cin), 32'(carry_in(a, bp, c0, n/(LAT+1))));
      end
      @(posedge clk); #1; n++;
    end
    chk("rsp_latency", 32'(n), 32'd12);
    chk("add_a_done", 32'({add_a, add_b, add_cin}), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_sum", 32'(rsp_sum), 32'(esum));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
    chk("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int seen;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp", 32'({rsp_valid, rsp_cout, rsp_ovf}), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 16'h2201, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 5, 16'h0001, 1'b1, 1'b1);
    do_op(16'h1000, 16'h0001, 1'b0, 1'b1, 0, 16'h0FFF, 1'b1, 1'b0);

    // Abort during WAIT of nibble 2: no response may follow.
    accept(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_rsp", 32'({rsp_valid, rsp_cout, rsp_ovf}), 32'd0);
    chk("abort_sum", 32'(rsp_sum), 32'd0);
    chk("abort_add", 32'({add_a, add_b, add_cin}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    chk("abort_no_rsp", 32'(seen), 32'd0);

    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 2, 16'h7FFF, 1'b1, 1'b1);
    do_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, 0, 16'h1001, 1'b0, 1'b0);
`ifdef CLA_SEQ_PERF_EN
    chk("perf_ops", 32'(perf_ops), 32'd3);
    chk("perf_busy", 32'(perf_busy), 32'd41);
`endif
    @(posedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
